// File: rtl/dealer_pkg.sv
// rtl/dealer_pkg.sv - shared constants, FSM states and requester encoding for card_dealer
package dealer_pkg;

    localparam int DECK_SIZE     = 52;
    localparam int CARD_W        = 6;
    localparam int LOAD_PERIOD   = 4;
    localparam int PEN_THRESHOLD = 12;

    typedef enum logic [2:0] {
        ST_CLR,
        ST_SHUF,
        ST_FILL,
        ST_READY,
        ST_GRANT
    } state_t;

    typedef enum logic {
        PLAYER = 1'b0,
        DEALER = 1'b1
    } req_id_t;

endpackage

// File: rtl/card_shoe.sv
// rtl/card_shoe.sv - deck storage with write pointer, read pointer and remaining-card counter
module card_shoe
    import dealer_pkg::*;
#(
    parameter int DEPTH = DECK_SIZE,
    parameter int W     = CARD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         arm,
    input  logic [W-1:0] arm_ptr,
    input  logic [W-1:0] arm_left,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic [W-1:0] wr_ptr,
    output logic [W-1:0] cards_left
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_ptr;

    assign rd_data = mem[rd_ptr];

    // card storage; contents are meaningless until the next fill completes
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // pointers and counter: cleared per shuffle, armed once the deck is complete
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cards_left <= '0;
        end else if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cards_left <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (arm) begin
                rd_ptr     <= arm_ptr;
                cards_left <= arm_left;
            end else if (rd_en) begin
                rd_ptr     <= rd_ptr + 1'b1;
                cards_left <= cards_left - 1'b1;
            end
        end
    end

endmodule

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - shuffler sequencing and round-robin card serving; CARD_DEALER_BURN_EN discards first card
module card_dealer
    import dealer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_round,
    output logic              shuf_clr,
    output logic              shuf_start,
    input  logic              shuf_load,
    input  logic [CARD_W-1:0] shuf_card,
    input  logic              player_req,
    input  logic              dealer_req,
    output logic              player_gnt,
    output logic              dealer_gnt,
    output logic [CARD_W-1:0] card_out,
    output logic [CARD_W-1:0] cards_left,
    output logic              ready,
    output logic              deck_empty
);

`ifdef CARD_DEALER_BURN_EN
    localparam int BURN = 1;
`else
    localparam int BURN = 0;
`endif

    localparam int PH_W = (LOAD_PERIOD > 1) ? $clog2(LOAD_PERIOD) : 1;

    state_t            state;
    req_id_t           last_gnt;
    req_id_t           pick;
    logic [PH_W-1:0]   ph;
    logic              phase_hit;
    logic              can_grant;
    logic              reshuffle;
    logic              shoe_clr;
    logic              shoe_wr;
    logic              wr_last;
    logic [CARD_W-1:0] rd_data;
    logic [CARD_W-1:0] wr_ptr;

    // ph tracks load cycles since the last sample point; the shuffler
    // presents a fresh card every LOAD_PERIOD load cycles
    assign phase_hit = (ph == PH_W'(LOAD_PERIOD - 1));
    assign shoe_clr  = (state == ST_CLR);
    assign shoe_wr   = (state == ST_FILL) && shuf_load && phase_hit;
    assign wr_last   = shoe_wr && (wr_ptr == CARD_W'(DECK_SIZE - 1));
    assign can_grant = (state == ST_READY) && (player_req || dealer_req) && (cards_left != '0);
    assign reshuffle = (state == ST_READY) && start_round && !can_grant
                       && (cards_left < CARD_W'(PEN_THRESHOLD));
    assign ready      = (state == ST_READY);
    assign deck_empty = ready && (cards_left == '0);

    // round-robin pick: on contention the side not served last wins
    always_comb begin
        pick = DEALER;
        if (player_req && dealer_req) begin
            pick = (last_gnt == PLAYER) ? DEALER : PLAYER;
        end else if (player_req) begin
            pick = PLAYER;
        end
    end

    card_shoe u_shoe (
        .clk        (clk),
        .rst        (rst),
        .clr        (shoe_clr),
        .wr_en      (shoe_wr),
        .wr_data    (shuf_card),
        .arm        (wr_last),
        .arm_ptr    (CARD_W'(BURN)),
        .arm_left   (CARD_W'(DECK_SIZE - BURN)),
        .rd_en      (can_grant),
        .rd_data    (rd_data),
        .wr_ptr     (wr_ptr),
        .cards_left (cards_left)
    );

    // main sequencer: clear, shuffle, fill, then serve with registered grants
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_CLR;
            shuf_clr   <= 1'b0;
            shuf_start <= 1'b0;
            player_gnt <= 1'b0;
            dealer_gnt <= 1'b0;
            card_out   <= '0;
            last_gnt   <= DEALER;
            ph         <= '0;
        end else begin
            shuf_clr   <= 1'b0;
            player_gnt <= 1'b0;
            dealer_gnt <= 1'b0;
            card_out   <= '0;
            case (state)
                ST_CLR: begin
                    shuf_clr <= 1'b1;
                    state    <= ST_SHUF;
                end
                ST_SHUF: begin
                    shuf_start <= 1'b1;
                    if (shuf_load) begin
                        ph    <= '0;
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (shuf_load) begin
                        ph <= phase_hit ? '0 : ph + 1'b1;
                        if (wr_last) begin
                            shuf_start <= 1'b0;
                            state      <= ST_READY;
                        end
                    end
                end
                ST_READY: begin
                    if (can_grant) begin
                        player_gnt <= (pick == PLAYER);
                        dealer_gnt <= (pick == DEALER);
                        card_out   <= rd_data;
                        last_gnt   <= pick;
                        state      <= ST_GRANT;
                    end else if (reshuffle) begin
                        state <= ST_CLR;
                    end
                end
                ST_GRANT: begin
                    state <= ST_READY;
                end
                default: begin
                    state <= ST_CLR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - directed scoreboard bench for card_dealer with a shuffler model
module tb_card_dealer;
    import dealer_pkg::*;

`ifdef CARD_DEALER_BURN_EN
    localparam int BURN = 1;
`else
    localparam int BURN = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start_round;
    logic              shuf_clr;
    logic              shuf_start;
    logic              shuf_load;
    logic [CARD_W-1:0] shuf_card;
    logic              player_req;
    logic              dealer_req;
    logic              player_gnt;
    logic              dealer_gnt;
    logic [CARD_W-1:0] card_out;
    logic [CARD_W-1:0] cards_left;
    logic              ready;
    logic              deck_empty;

    int total = 0;
    int bad   = 0;
    int cnt_m;
    int mult  = 1;
    int off   = 0;
    logic gap;
    int exp_left;
    bit last_p;
    logic [CARD_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    card_dealer dut (
        .clk         (clk),
        .rst         (rst),
        .start_round (start_round),
        .shuf_clr    (shuf_clr),
        .shuf_start  (shuf_start),
        .shuf_load   (shuf_load),
        .shuf_card   (shuf_card),
        .player_req  (player_req),
        .dealer_req  (dealer_req),
        .player_gnt  (player_gnt),
        .dealer_gnt  (dealer_gnt),
        .card_out    (card_out),
        .cards_left  (cards_left),
        .ready       (ready),
        .deck_empty  (deck_empty)
    );

    function automatic int perm(input int k, input int m, input int o);
        return (k * m + o) % DECK_SIZE;
    endfunction

    // shuffler model: loads follow shuf_start a cycle later; card k is on the
    // bus at load cycle k*LOAD_PERIOD+1 (k>=1 maps to deck position k-1)
    always @(posedge clk) begin
        if (!rst || shuf_clr) begin
            cnt_m     <= 0;
            shuf_load <= 1'b0;
        end else begin
            shuf_load <= shuf_start && !gap;
            if (shuf_load) cnt_m <= cnt_m + 1;
        end
    end

    always_comb begin
        shuf_card = '0;
        if (cnt_m >= 1) shuf_card = CARD_W'(perm(((cnt_m - 1) / LOAD_PERIOD) % DECK_SIZE, mult, off));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_deck(input int m, input int o);
        mult = m;
        off  = o;
        exp_q.delete();
        for (int k = BURN; k < DECK_SIZE; k++) exp_q.push_back(CARD_W'(perm(k, m, o)));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 400) begin
            step();
            n++;
        end
        chk("fill_done", ready, 1);
        chk("fill_loads", cnt_m, LOAD_PERIOD * DECK_SIZE + 1);
        chk("fill_left", cards_left, DECK_SIZE - BURN);
        exp_left = DECK_SIZE - BURN;
    endtask

    task automatic check_grant(input bit who_p);
        logic [CARD_W-1:0] ec;
        ec = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        exp_left--;
        chk("gnt_pd", {player_gnt, dealer_gnt}, who_p ? 2'b10 : 2'b01);
        chk("card", card_out, ec);
        chk("left", cards_left, exp_left);
        last_p = who_p;
    endtask

    task automatic grants(input bit p, input bit d, input int n);
        player_req = p;
        dealer_req = d;
        for (int i = 0; i < n; i++) begin
            step();
            check_grant((p && d) ? !last_p : p);
            if (i == n - 1) begin
                player_req = 1'b0;
                dealer_req = 1'b0;
            end
            step();
            chk("idle", {player_gnt, dealer_gnt, ready}, 3'b001);
        end
    endtask

    task automatic check_reset(input string tag);
        chk(tag, {shuf_clr, shuf_start, player_gnt, dealer_gnt, ready, deck_empty}, 6'b0);
        chk({tag, "_card"}, card_out, 0);
        chk({tag, "_left"}, cards_left, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; start_round = 1'b0; player_req = 1'b0; dealer_req = 1'b0; gap = 1'b0;
        last_p = 1'b0;
        step(); step();
        check_reset("reset");

        // first fill with cards 0..51 and a mid-fill load gap
        load_deck(1, 0);
        rst = 1'b1;
        step(); chk("clr_pulse", {shuf_clr, shuf_start}, 2'b10);
        step(); chk("start_lvl", {shuf_clr, shuf_start}, 2'b01);
        repeat (60) step();
        gap = 1'b1;
        repeat (12) step();
        chk("gap_hold", {ready, shuf_start}, 2'b01);
        gap = 1'b0;
        wait_ready();

        // single player request, then contention alternation
        grants(1'b1, 1'b0, 1);
        grants(1'b1, 1'b1, 4);

        // drain to threshold: start_round must be ignored at 12 cards
        grants(1'b0, 1'b1, exp_left - PEN_THRESHOLD);
        chk("at_thresh", cards_left, PEN_THRESHOLD);
        start_round = 1'b1; step(); start_round = 1'b0;
        chk("no_resh", {ready, shuf_clr}, 2'b10);
        step(); chk("no_resh2", {ready, shuf_clr}, 2'b10);

        // start_round with a request in the same cycle: grant wins
        player_req = 1'b1; start_round = 1'b1; step();
        player_req = 1'b0; start_round = 1'b0;
        check_grant(1'b1);
        step(); chk("drop_sr", ready, 1);
        step(); chk("drop_sr2", {ready, shuf_clr}, 2'b10);
        chk("below", cards_left, PEN_THRESHOLD - 1);

        // below threshold: reshuffle
        load_deck(5, 3);
        start_round = 1'b1; step(); start_round = 1'b0;
        chk("resh_leave", ready, 0);
        step(); chk("resh_clr", shuf_clr, 1);
        wait_ready();

        // empty shoe: dealer waits until reshuffle
        grants(1'b1, 1'b0, exp_left);
        dealer_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("empty_hold", {player_gnt, dealer_gnt, deck_empty}, 3'b001);
        end
        load_deck(7, 11);
        start_round = 1'b1; step(); start_round = 1'b0;
        wait_ready();
        step();
        check_grant(1'b0);
        dealer_req = 1'b0;
        step();

        // reset mid-fill
        rst = 1'b0; step(); check_reset("reset2");
        rst = 1'b1;
        repeat (45) step();
        chk("in_fill", {shuf_start, ready}, 2'b10);
        #2; rst = 1'b0; #1;
        check_reset("async_rst");
        last_p = 1'b0;
        load_deck(11, 5);
        step(); step();
        rst = 1'b1;
        step(); chk("clr_pulse2", {shuf_clr, shuf_start}, 2'b10);
        step(); chk("start_lvl2", {shuf_clr, shuf_start}, 2'b01);
        wait_ready();
        grants(1'b1, 1'b1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
# card_dealer

Sequences the shuffle engine and shares its output between the two hand-building requesters (player, dealer). Clears and starts the shuffler, captures its serial card stream into an internal shoe, then serves single-card requests under round-robin arbitration until the shoe falls below the penetration threshold, when it reshuffles at the next round boundary. Sits between the shuffle engine and the blackjack game FSM.

## Interface
- DECK_SIZE, 52, cards per shuffled deck
- CARD_W, 6, card index width
- LOAD_PERIOD, 4, clocks between successive cards from the shuffler
- PEN_THRESHOLD, 12, reshuffle at round start when cards_left < this value
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start_round  in  1  one-cycle pulse from game FSM marking a round boundary
- shuf_clr  out  1  one-cycle clear pulse to shuffler (drives its active-high rst)
- shuf_start  out  1  level, drives shuffler shuffleFlag
- shuf_load  in  1  shuffler loadFlag
- shuf_card  in  CARD_W  shuffler card output
- player_req, dealer_req  in  1 each  level request, held until granted
- player_gnt, dealer_gnt  out  1 each  one-cycle grant
- card_out  out  CARD_W  dealt card, valid only in a grant cycle
- cards_left  out  CARD_W  cards remaining in shoe
- ready  out  1  shoe serving requests
- deck_empty  out  1  cards_left == 0 in READY

## Operation
- States: CLR, SHUF, FILL, READY, GRANT.
- Reset: state CLR; all outputs 0; cards_left 0; last_gnt = dealer.
- CLR: shuf_clr=1 for one cycle → SHUF.
- SHUF: shuf_start=1 (held through FILL); wait for shuf_load=1 → FILL.
- FILL: count cycles with shuf_load=1 (cnt starts at 1 on the first). Shuffler updates shuf_card after every LOAD_PERIOD such cycles; sample shuf_card into shoe[wr_ptr] when cnt == k·LOAD_PERIOD+1, k ≥ 1. After DECK_SIZE writes: shuf_start=0, rd_ptr=0, cards_left=DECK_SIZE → READY.
- READY: ready=1. If any req and cards_left≠0 → GRANT. Both requesting: grant the one not in last_gnt.
- GRANT (one cycle): selected gnt=1, card_out=shoe[rd_ptr]; rd_ptr+1, cards_left−1, last_gnt updated → READY.
- start_round in READY with no grant pending and cards_left < PEN_THRESHOLD → CLR. Otherwise ignored (including in all other states).
- Empty shoe: requests stay pending, no grant, deck_empty=1 until start_round triggers reshuffle.
- start_round and a request in the same READY cycle: grant wins; start_round is dropped.

## Timing
- Reset to first shuf_start: 2 clocks (CLR, then SHUF).
- Fill latency from first shuf_load: DECK_SIZE·LOAD_PERIOD+1 clocks.
- Request in READY → gnt on next edge (1-cycle latency). Max one grant per 2 clocks.
- Requester must drop req in the cycle after gnt, or it is granted again.
- shuf_load dropping mid-FILL: the controller holds its counter and waits. No timeout.
- Reset asserted mid-operation: immediate return to reset values. Shoe contents are don't-care.

## Configuration
- CARD_DEALER_BURN_EN defined: the first card after each FILL is discarded. rd_ptr starts at 1 and cards_left at DECK_SIZE−1 on entering READY.
- Undefined: no burn card; behaviour as above.

## Structure
- Package dealer_pkg holds:
  - the state enum
  - DECK_SIZE, CARD_W, LOAD_PERIOD defaults
  - the requester encoding (PLAYER=0, DEALER=1)
- Sub-module card_shoe: DECK_SIZE×CARD_W storage with write pointer, read pointer, and the cards_left counter.
- Arbitration and the FSM live in card_dealer.

## Test plan
- Reset release, shuffler model streams cards 0..51 → shuf_clr pulse at cycle 1, shuf_start high at cycle 2, ready after 209 load cycles, cards_left=52.
- player_req held alone → player_gnt one cycle later, card_out=first captured card, cards_left=51.
- player_req and dealer_req both held from READY, after reset → grants alternate P,D,P,D with one idle cycle between each; cards consumed in capture order.
- Drain to 11 cards, pulse start_round → shuf_clr, new fill, cards_left=52. Repeat at 12 cards → no reshuffle.
- Drain to 0 with dealer_req held → no grant, deck_empty=1. start_round → reshuffle, then dealer_gnt.
- Reset pulsed mid-FILL → all outputs 0, sequence restarts from CLR. With CARD_DEALER_BURN_EN → first grant returns the second captured card, cards_left=50 after it.
